// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserializer.
//   state_t       : receiver FSM states (IDLE, RECV)
//   DEFAULT_WIDTH : default word length in bits
package deser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter for the serial deserializer.
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   Clear    : synchronous clear to 0 (has priority over Enable)
//   Enable   : count one accepted bit this cycle
//   Count    : registered number of bits accepted in the current frame
//   Terminal : high in the cycle whose Enable brings Count up to WIDTH
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Clear,
  input  logic          Enable,
  output logic [CW-1:0] Count,
  output logic          Terminal
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (Enable) begin
      Count <= Count + 1'b1;
    end
  end

  // Flags the edge that accepts the last bit of a word, so the parent can
  // move the completed word out on that same edge.
  assign Terminal = Enable && !Clear && (Count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with a one-word holding register.
// Bits arrive LSB first on Serial_In, qualified by Shift_En, within a frame
// opened by Start. A completed word is moved into Data_Out and offered to the
// consumer with a valid/ready handshake.
// Ports:
//   Clk, Reset_n  : clock (rising edge) and asynchronous active-low reset
//   Start         : pulse, opens or restarts a frame (clears partial word)
//   Shift_En      : Serial_In carries a valid bit this cycle
//   Serial_In     : serial data bit, LSB first
//   Data_Ready    : consumer accepts Data_Out this cycle
//   Clear_Overrun : pulse, clears the sticky Overrun flag
//   Data_Out      : last completed word
//   Data_Valid    : Data_Out holds a word not yet accepted
//   Busy          : receiver is in RECV (doubles as the FSM state view)
//   Bit_Count     : bits accepted in the current frame
//   Overrun       : sticky, a completed word was dropped
//
// Handshake: a word transfers on every rising edge where Data_Valid=1 and
// Data_Ready=1. Data_Valid may rise regardless of Data_Ready, and Data_Out
// stays frozen while Data_Valid=1 until that transfer edge.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Start,
  input  logic                       Shift_En,
  input  logic                       Serial_In,
  input  logic                       Data_Ready,
  input  logic                       Clear_Overrun,
  output logic [WIDTH-1:0]           Data_Out,
  output logic                       Data_Valid,
  output logic                       Busy,
  output logic [$clog2(WIDTH+1)-1:0] Bit_Count,
  output logic                       Overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] next_word;
  logic             shift_ok;
  logic             word_done;
  logic             hold_free;

  // A bit is taken only inside a frame, and never on a Start cycle.
  assign shift_ok  = (state_q == RECV) && Shift_En && !Start;
  assign next_word = {Serial_In, shift_q[WIDTH-1:1]};
  // Holding register can take a new word if empty or being emptied now.
  assign hold_free = !Data_Valid || Data_Ready;

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Clear    (Start),
    .Enable   (shift_ok),
    .Count    (Bit_Count),
    .Terminal (word_done)
  );

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = RECV;
    end else if (word_done) begin
      state_d = IDLE;
    end
  end

  assign Busy = (state_q == RECV);

  // Shift register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_q <= '0;
    end else if (Start) begin
      shift_q <= '0;
    end else if (shift_ok) begin
      shift_q <= next_word;
    end
  end

  // Holding register and handshake; Start never touches these.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
    end else if (word_done && hold_free) begin
      Data_Out   <= next_word;
      Data_Valid <= 1'b1;
    end else if (Data_Valid && Data_Ready) begin
      Data_Valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Overrun <= 1'b0;
    end else if (word_done && !hold_free) begin
      Overrun <= 1'b1;
    end else if (Clear_Overrun) begin
      Overrun <= 1'b0;
    end
  end

endmodule
